// File: rtl/uart_echo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo
//  Purpose  : 8N1 UART loopback. Each valid received byte passes through a
//             one-byte holding register and is retransmitted on tx_o.
//  Revision : 1.0  initial release
// ============================================================================
module uart_echo #(
    parameter int CLK_FREQ_HZ  = 32256000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic tx_o
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Reset asserts asynchronously; release is held for two clocks so every
    // flop leaves reset on the same edge.
    logic [1:0] r_rst_pipe;
    logic       w_rst_hold;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_rst_pipe <= 2'b11;
        else       r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end

    assign w_rst_hold = r_rst_pipe[1];

    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    rx_state_t          r_rx_state, w_rx_state_next;
    logic [c_CNT_W-1:0] r_rx_cnt,   w_rx_cnt_next;
    logic [2:0]         r_rx_bit,   w_rx_bit_next;
    logic [7:0]         r_rx_shift, w_rx_shift_next;
    logic               w_rx_byte_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_next;
            r_rx_cnt   <= w_rx_cnt_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt + 1'b1;
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_byte_valid = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_next = '0;
                if (r_rx_prev && !r_rx_sync) w_rx_state_next = RX_START;
            end
            RX_START: begin
                // A start bit that is no longer low at mid-bit is a glitch.
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_cnt_next   = '0;
                    w_rx_bit_next   = '0;
                    w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_next   = '0;
                    w_rx_shift_next = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_bit_next   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_next   = '0;
                    w_rx_byte_valid = r_rx_sync;
                    w_rx_state_next = RX_IDLE;
                end
            end
            default: w_rx_state_next = RX_IDLE;
        endcase
        if (w_rst_hold) begin
            w_rx_state_next = RX_IDLE;
            w_rx_cnt_next   = '0;
            w_rx_bit_next   = '0;
            w_rx_shift_next = '0;
            w_rx_byte_valid = 1'b0;
        end
    end

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       w_xfer;

    assign w_xfer = tx_valid && tx_ready;

    // A byte arriving while one is still held is dropped unless the held
    // byte is being handed to the transmitter on the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (w_rst_hold) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (w_rx_byte_valid && (!tx_valid || w_xfer)) begin
            tx_valid <= 1'b1;
            tx_data  <= r_rx_shift;
        end else if (w_xfer) begin
            tx_valid <= 1'b0;
        end
    end

    tx_state_t          r_tx_state, w_tx_state_next;
    logic [c_CNT_W-1:0] r_tx_cnt,   w_tx_cnt_next;
    logic [2:0]         r_tx_bit,   w_tx_bit_next;
    logic [7:0]         r_tx_shift, w_tx_shift_next;
    logic               r_tx_out,   w_tx_out_next;

    assign tx_ready = (r_tx_state == TX_IDLE);
    assign tx_o     = r_tx_out;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_out   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_out   <= w_tx_out_next;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt + 1'b1;
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_tx_out_next   = r_tx_out;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_next = '0;
                w_tx_out_next = 1'b1;
                if (tx_valid) begin
                    w_tx_shift_next = tx_data;
                    w_tx_bit_next   = '0;
                    w_tx_out_next   = 1'b0;
                    w_tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_next   = '0;
                    w_tx_out_next   = r_tx_shift[0];
                    w_tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                // The line value for the next bit is registered one bit ahead.
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_next   = '0;
                    w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_next   = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_out_next   = 1'b1;
                        w_tx_state_next = TX_STOP;
                    end else begin
                        w_tx_out_next = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_next   = '0;
                    w_tx_out_next   = 1'b1;
                    w_tx_state_next = TX_IDLE;
                end
            end
            default: w_tx_state_next = TX_IDLE;
        endcase
        if (w_rst_hold) begin
            w_tx_state_next = TX_IDLE;
            w_tx_cnt_next   = '0;
            w_tx_bit_next   = '0;
            w_tx_shift_next = '0;
            w_tx_out_next   = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_echo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_echo
//  Purpose  : Scoreboard bench for uart_echo: handshake and serial-line
//             monitors pop expected bytes pushed by the stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_echo;

    localparam int CPB = 280;

    logic clk = 1'b0;
    logic rst_i;
    logic rx_i;
    logic tx_o;

    always #5 clk = ~clk;

    uart_echo #(
        .CLK_FREQ_HZ (32256000),
        .BAUD_RATE   (115200)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .rx_i  (rx_i),
        .tx_o  (tx_o)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_xfer   = 0;
    int n_fall   = 0;
    logic [9:0] last_frame = '0;
    logic [7:0] q_hs[$];
    logic [7:0] q_ser[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake monitor: every transfer must carry the next expected byte.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (rst_i !== 1'b0) continue;
            if (dut.tx_valid && dut.tx_ready) begin
                n_xfer++;
                if (q_hs.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL xfer_unexpected: tx_data=%h with no byte expected", dut.tx_data);
                end else begin
                    exp_b = q_hs.pop_front();
                    check("xfer_data", {24'h0, dut.tx_data}, {24'h0, exp_b});
                end
            end
        end
    end

    // Serial monitor: checks every cycle of each echoed frame, so bit
    // values and exact bit durations are both covered.
    initial begin
        logic       prev;
        logic       have;
        logic       bad;
        logic       aborted;
        logic [7:0] exp_b;
        logic [9:0] frame;
        logic [9:0] got;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_i !== 1'b0) begin
                prev = 1'b1;
                continue;
            end
            if (prev && (tx_o === 1'b0)) begin
                n_fall++;
                have  = (q_ser.size() != 0);
                exp_b = have ? q_ser.pop_front() : 8'h00;
                frame = {1'b1, exp_b, 1'b0};
                got   = '0;
                bad   = 1'b0;
                aborted = 1'b0;
                for (int off = 0; off < 10 * CPB; off++) begin
                    if (off > 0) @(negedge clk);
                    if (rst_i !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (off % CPB == CPB / 2) got[off / CPB] = tx_o;
                    if (tx_o !== frame[off / CPB]) bad = 1'b1;
                end
                if (!aborted) begin
                    last_frame = got;
                    checks++;
                    if (!have || bad) begin
                        failures++;
                        $display("FAIL tx_frame: got frame %b (bits first-to-last from bit0) expected %b, byte expected=%0d",
                                 got, frame, have);
                    end
                end
                prev = 1'b1;
            end else begin
                prev = tx_o;
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        q_hs.push_back(d);
        q_ser.push_back(d);
        send_frame(d, 1'b1);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        logic pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < max_cyc) begin
            @(negedge clk);
            n++;
            pending = (q_hs.size() != 0) || (q_ser.size() != 0) || !dut.tx_ready || dut.tx_valid;
        end
        checks++;
        if (pending) begin
            failures++;
            $display("FAIL %s: timeout, pending hs=%0d ser=%0d expected both 0",
                     name, q_hs.size(), q_ser.size());
        end
    endtask

    task automatic idle_quiet(input string name, input int ncyc);
        int f0;
        logic bad;
        f0  = n_fall;
        bad = 1'b0;
        repeat (ncyc) begin
            @(negedge clk);
            if (tx_o !== 1'b1) bad = 1'b1;
        end
        check({name, "_tx_high"}, {31'h0, bad}, 32'h0);
        check({name, "_no_frame"}, n_fall - f0, 32'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int x0;
        int t_load;
        int t_fall;
        int n;
        logic bad;

        // 1. reset behaviour
        rst_i = 1'b1;
        rx_i  = 1'b1;
        bad   = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || dut.tx_valid !== 1'b0) bad = 1'b1;
        end
        check("reset_hold_idle", {31'h0, bad}, 32'h0);
        rst_i = 1'b0;
        idle_quiet("post_reset", 1000);

        // 2. single echo with latency measurement
        x0     = n_xfer;
        t_load = 0;
        t_fall = 0;
        fork
            send_byte(8'h41);
            begin
                n = 0;
                while (dut.tx_valid !== 1'b1 && n < 20 * CPB) begin
                    @(negedge clk);
                    n++;
                end
                t_load = cyc;
                n = 0;
                while (tx_o !== 1'b0 && n < 4 * CPB) begin
                    @(negedge clk);
                    n++;
                end
                t_fall = cyc;
            end
        join
        check("echo_latency_le3", {31'h0, (t_fall - t_load) <= 3}, 32'h1);
        wait_drain("drain_41", 40 * CPB);
        check("frame_0x41", {22'h0, last_frame}, {22'h0, 10'b1010000010});
        check("xfer_count_41", n_xfer - x0, 32'd1);

        // 3. back-to-back frames
        x0 = n_xfer;
        n  = n_fall;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h55);
        wait_drain("drain_b2b", 40 * CPB);
        check("xfer_count_b2b", n_xfer - x0, 32'd3);
        check("frame_count_b2b", n_fall - n, 32'd3);

        // 4. glitch rejection
        x0   = n_xfer;
        rx_i = 1'b0;
        repeat (100) @(negedge clk);
        rx_i = 1'b1;
        idle_quiet("glitch", 1000);
        check("xfer_count_glitch", n_xfer - x0, 32'd0);
        send_byte(8'hA5);
        wait_drain("drain_a5", 40 * CPB);
        check("xfer_count_a5", n_xfer - x0, 32'd1);

        // 5. framing error
        x0 = n_xfer;
        send_frame(8'h3C, 1'b0);
        rx_i = 1'b1;
        idle_quiet("framing", 1000);
        check("xfer_count_framing", n_xfer - x0, 32'd0);
        send_byte(8'h3C);
        wait_drain("drain_3c", 40 * CPB);
        check("xfer_count_3c", n_xfer - x0, 32'd1);

        // 6. reset during echo data bit 4
        n = n_fall;
        fork
            send_byte(8'h7E);
        join_none
        x0 = 0;
        while (n_fall == n && x0 < 20 * CPB) begin
            @(negedge clk);
            x0++;
        end
        check("rst_tx_started", {31'h0, n_fall != n}, 32'h1);
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        check("tx_busy_before_reset", {31'h0, dut.tx_ready}, 32'h0);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_tx_high", {31'h0, tx_o}, 32'h1);
        check("rst_tx_idle", {31'h0, dut.tx_ready}, 32'h1);
        check("rst_no_valid", {31'h0, dut.tx_valid}, 32'h0);
        repeat (10) @(negedge clk);
        rst_i = 1'b0;
        q_hs.delete();
        q_ser.delete();
        idle_quiet("after_rst", 3000);
        x0 = n_xfer;
        send_byte(8'h7E);
        wait_drain("drain_7e", 40 * CPB);
        check("xfer_count_7e", n_xfer - x0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_echo.md
Name: uart_echo

Overview:
Loopback UART block: receives 8N1 serial bytes on rx_i and retransmits each valid byte unchanged on tx_o.
- Built from a UART receiver, a one-byte holding register, and a UART transmitter.
- Receiver and transmitter are joined by an internal valid/ready handshake whose signals are named tx_valid, tx_ready and tx_data. Benches probe these hierarchically.
- Used as the board-level serial bring-up block ahead of the ALU command path.

Parameters:
- CLK_FREQ_HZ, 32256000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (= 280), clock cycles per serial bit. Must be ≥ 4.

Ports:
- clk_i  input  1  system clock, 32.256 MHz nominal, rising-edge.
- rst_i  input  1  asynchronous, active-high reset.
- rx_i  input  1  asynchronous serial input; idle high.
- tx_o  output  1  serial output; idle high.

Behaviour:
Clock and reset
- Single clock domain: clk_i. rst_i is asynchronous and active-high.
- While rst_i is high:
  - tx_o = 1.
  - Receiver and transmitter are in IDLE.
  - Holding register is empty (tx_valid = 0).
  - All bit and baud counters are 0.
- Reset asserted mid-frame aborts RX and TX immediately. tx_o returns high asynchronously, and no partial byte is delivered or retransmitted.
- Deassertion is synchronised internally.

Frame format
- 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Every bit lasts exactly CLKS_PER_BIT cycles.

RX input conditioning
- rx_i passes through a 2-flop synchroniser (reset value 1) before any use.

Receiver FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE
- RX_IDLE: a synchronised high-to-low transition enters RX_START and clears the baud counter.
- RX_START:
  - After CLKS_PER_BIT/2 cycles, re-sample the line.
  - Low: enter RX_DATA.
  - High: treat as a glitch and return to RX_IDLE.
- RX_DATA: sample every CLKS_PER_BIT cycles (mid-bit). Shift into bit index 0..7, LSB first. After bit 7, enter RX_STOP.
- RX_STOP: sample CLKS_PER_BIT cycles after bit 7.
  - 1: byte is valid. On that cycle, load tx_data and set tx_valid = 1.
  - 0: framing error. Discard the byte; tx_valid is unchanged.
  - Either way, go to RX_IDLE. The receiver can detect a new start edge on the next cycle.

Holding register and handshake
- tx_data is 8 bits; tx_valid is 1 bit.
- tx_valid stays high until the cycle where tx_valid && tx_ready. That cycle is the transfer, and tx_valid clears on it.
- A new valid byte arriving while tx_valid = 1 is dropped; the held byte is preserved.
- If the transfer and a new load coincide, the new byte is loaded and tx_valid stays 1.

Transmitter FSM: TX_IDLE -> TX_START -> TX_DATA -> TX_STOP -> TX_IDLE
- tx_ready = 1 only in TX_IDLE.
- On a transfer, latch tx_data into the shift register and enter TX_START. tx_o goes 0 on the next clock edge.
- TX_START, each of the 8 TX_DATA bits, and TX_STOP (tx_o = 1) each last exactly CLKS_PER_BIT cycles.
- Then return to TX_IDLE and assert tx_ready.
- Latency: the echo start bit begins ≤ 3 cycles after the RX stop-bit sample.
- tx_o is registered and glitch-free.

Throughput
- Back-to-back input frames at the same baud are echoed without loss. TX completes its frame before RX completes the next one.

Test Plan:
1. Reset behaviour: hold rst_i = 1 for 100 cycles while rx_i = 1 -> tx_o = 1, tx_valid = 0 throughout. Release reset and idle for 1000 cycles -> tx_o stays 1.
2. Single echo: send 0x41 at 280 cycles/bit -> exactly one tx_valid && tx_ready cycle with tx_data = 0x41. tx_o emits 0,1,0,0,0,0,0,1,0,1, each 280 cycles. Start bit begins ≤ 3 cycles after the RX stop sample.
3. Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap -> echoed in order, each frame exactly 10×280 cycles, no drops.
4. Glitch rejection: pulse rx_i low for 100 cycles -> no transfer, tx_o stays 1. A following 0xA5 frame is echoed correctly.
5. Framing error: send 0x3C with stop bit = 0 -> no transfer and no TX activity. A subsequent valid 0x3C is echoed.
6. Reset mid-TX: assert rst_i during echo data bit 4 -> tx_o = 1 immediately, no further TX. After release, a new 0x7E is echoed correctly.
